// File: rtl/m_tstate_sequencer_pkg.sv
// Shared definitions for the T-state sequencer: FSM encoding, default sizes
// and the T-state index at which a halt strobe is honoured.
package m_tstate_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } seqState_t;

   localparam int DEFAULT_NUM_T = 18;
   localparam int DEFAULT_CNT_W = 16;
   localparam int HALT_T_INDEX  = 3;

endpackage

// File: rtl/m_tstate_sequencer_ring.sv
// One-hot T-state ring. Clear wins over load, and load wins over shift.
// Shifting out of the last T-state rotates back into T0.
module mRingCounter
   import m_tstate_sequencer_pkg::*;
#(
   parameter int NUM_T = DEFAULT_NUM_T
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             loadT0,
   input  logic             shift,
   input  logic             clear,
   output logic [NUM_T-1:0] tstate
);

   localparam logic [NUM_T-1:0] T0_VEC = NUM_T'(1);

   // Ring register: synchronous active-low reset empties the ring
   always_ff @(posedge clk) begin
      if (!rstN) begin
         tstate <= '0;
      end else if (clear) begin
         tstate <= '0;
      end else if (loadT0) begin
         tstate <= T0_VEC;
      end else if (shift) begin
         tstate <= {tstate[NUM_T-2:0], tstate[NUM_T-1]};
      end
   end

endmodule

// File: rtl/m_tstate_sequencer.sv
// T-state sequencer: IDLE/RUN/HALTED control FSM that drives the one-hot
// ring, counts retired instructions and flags ring overruns.
module m_tstate_sequencer
   import m_tstate_sequencer_pkg::*;
#(
   parameter int NUM_T = DEFAULT_NUM_T,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             iClk,
   input  logic             iRST_n,
   input  logic             iRun,
   input  logic             iRestart_n,
   input  logic             iHalt,
   input  logic             iStepMode,
   input  logic             iStep,
   output logic [NUM_T-1:0] oTstate,
   output logic             oRunning,
   output logic             oHalted,
   output logic             oInstrDone,
   output logic [CNT_W-1:0] oInstrCount,
   output logic             oFault
);

   seqState_t state;
   seqState_t nextState;
   logic      loadT0;
   logic      shift;
   logic      clear;
   logic      retire;
   logic      overrun;
   logic      advanceEn;

   // FSM state register
   always_ff @(posedge iClk) begin
      if (!iRST_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next state and ring controls; in RUN the order is halt, restart, advance, hold
   always_comb begin
      nextState = state;
      loadT0    = 1'b0;
      shift     = 1'b0;
      clear     = 1'b0;
      retire    = 1'b0;
      overrun   = 1'b0;
      advanceEn = !iStepMode || iStep;
      case (state)
         IDLE, HALTED: begin
            if (iRun) begin
               nextState = RUN;
               loadT0    = 1'b1;
            end
         end
         RUN: begin
            if (iHalt && oTstate[HALT_T_INDEX]) begin
               nextState = HALTED;
               clear     = 1'b1;
            end else if (!iRestart_n) begin
               loadT0 = 1'b1;
               retire = 1'b1;
            end else if (advanceEn) begin
               shift   = 1'b1;
               overrun = oTstate[NUM_T-1];
            end
         end
         default: begin
            nextState = IDLE;
            clear     = 1'b1;
         end
      endcase
   end

   mRingCounter #(
      .NUM_T (NUM_T)
   ) ring (
      .clk    (iClk),
      .rstN   (iRST_n),
      .loadT0 (loadT0),
      .shift  (shift),
      .clear  (clear),
      .tstate (oTstate)
   );

   // Retirement pulse, wrapping instruction counter and sticky overrun flag
   always_ff @(posedge iClk) begin
      if (!iRST_n) begin
         oInstrDone  <= 1'b0;
         oInstrCount <= '0;
         oFault      <= 1'b0;
      end else begin
         oInstrDone <= retire;
         if (retire) begin
            oInstrCount <= oInstrCount + CNT_W'(1);
         end
         if (overrun) begin
            oFault <= 1'b1;
         end
      end
   end

   assign oRunning = (state == RUN);
   assign oHalted  = (state == HALTED);

endmodule

// File: tb/tb_m_tstate_sequencer.sv
// Bench for the T-state sequencer: directed scenarios plus randomized
// traffic compared against a behavioural model of the sequencing rules.
module tb_m_tstate_sequencer;

   localparam int NUM_T = 18;
   localparam int CNT_W = 16;

   logic             iClk = 1'b0;
   logic             rstN = 1'b0;
   logic             run = 1'b0;
   logic             restartN = 1'b1;
   logic             halt = 1'b0;
   logic             stepMode = 1'b0;
   logic             step = 1'b0;
   logic [NUM_T-1:0] tstate;
   logic             running;
   logic             halted;
   logic             instrDone;
   logic [CNT_W-1:0] instrCount;
   logic             fault;

   int testsRun = 0;
   int testsFailed = 0;

   // Model: mode 0 = idle, 1 = running, 2 = halted; mT = -1 means no T-state
   int mMode = 0;
   int mT = -1;
   int mCount = 0;
   bit mFault = 1'b0;
   bit mDone = 1'b0;

   m_tstate_sequencer #(
      .NUM_T (NUM_T),
      .CNT_W (CNT_W)
   ) dut (
      .iClk        (iClk),
      .iRST_n      (rstN),
      .iRun        (run),
      .iRestart_n  (restartN),
      .iHalt       (halt),
      .iStepMode   (stepMode),
      .iStep       (step),
      .oTstate     (tstate),
      .oRunning    (running),
      .oHalted     (halted),
      .oInstrDone  (instrDone),
      .oInstrCount (instrCount),
      .oFault      (fault)
   );

   // Free-running clock
   always #5 iClk = ~iClk;

   function automatic logic [NUM_T-1:0] oneHot(input int idx);
      logic [NUM_T-1:0] v;
      v = '0;
      if (idx >= 0) v[idx] = 1'b1;
      return v;
   endfunction

   // Advance the model by one clock using the inputs seen at this edge
   task automatic modelStep();
      if (!rstN) begin
         mMode = 0; mT = -1; mCount = 0; mFault = 1'b0; mDone = 1'b0;
      end else begin
         mDone = 1'b0;
         if (mMode == 0 || mMode == 2) begin
            if (run) begin
               mMode = 1; mT = 0;
            end
         end else begin
            if (halt && mT == 3) begin
               mMode = 2; mT = -1;
            end else if (!restartN) begin
               mT = 0; mDone = 1'b1; mCount = (mCount + 1) % (1 << CNT_W);
            end else if (!stepMode || step) begin
               if (mT == NUM_T - 1) begin
                  mT = 0; mFault = 1'b1;
               end else begin
                  mT = mT + 1;
               end
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge iClk);
      modelStep();
      #1;
   endtask

   task automatic applyReset();
      rstN = 1'b0; run = 1'b0; restartN = 1'b1; halt = 1'b0; stepMode = 1'b0; step = 1'b0;
      tick();
      rstN = 1'b1;
   endtask

   task automatic test_reset();
      applyReset();
      applyReset();
      testsRun++;
      if ({tstate, running, halted, instrDone, instrCount, fault} !== '0) begin
         testsFailed++;
         $display("[TB] FAIL reset: tstate=%h run=%b halt=%b done=%b cnt=%0d fault=%b, expected all zero",
                  tstate, running, halted, instrDone, instrCount, fault);
      end
   endtask

   task automatic test_nop_restart();
      int doneSeen;
      doneSeen = 0;
      run = 1'b1;
      tick();
      run = 1'b0;
      for (int k = 0; k <= 3; k++) begin
         testsRun++;
         if (tstate !== oneHot(k) || running !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL nop_seq T%0d: tstate=%h running=%b, expected %h running=1", k, tstate, running, oneHot(k));
         end
         if (instrDone) doneSeen++;
         if (k == 3) restartN = 1'b0;
         tick();
      end
      restartN = 1'b1;
      if (instrDone) doneSeen++;
      testsRun++;
      if (tstate !== oneHot(0) || instrDone !== 1'b1 || instrCount !== 16'd1) begin
         testsFailed++;
         $display("[TB] FAIL nop_retire: tstate=%h done=%b cnt=%0d, expected %h done=1 cnt=1", tstate, instrDone, instrCount, oneHot(0));
      end
      tick();
      if (instrDone) doneSeen++;
      testsRun++;
      if (doneSeen != 1 || tstate !== oneHot(1)) begin
         testsFailed++;
         $display("[TB] FAIL nop_once: dones=%0d tstate=%h, expected 1 done tstate=%h", doneSeen, tstate, oneHot(1));
      end
   endtask

   task automatic test_halt();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      testsRun++;
      if (tstate !== oneHot(2) || running !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL halt_ignored: tstate=%h running=%b, expected %h running=1", tstate, running, oneHot(2));
      end
      tick();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      testsRun++;
      if (tstate !== '0 || halted !== 1'b1 || running !== 1'b0 || instrCount !== 16'd1 || instrDone !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL halt_enter: tstate=%h halted=%b running=%b cnt=%0d done=%b, expected 0 1 0 1 0",
                  tstate, halted, running, instrCount, instrDone);
      end
      step = 1'b1;
      stepMode = 1'b1;
      tick();
      step = 1'b0;
      stepMode = 1'b0;
      testsRun++;
      if (tstate !== '0 || halted !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL halt_hold: tstate=%h halted=%b, expected 0 halted=1", tstate, halted);
      end
      run = 1'b1;
      tick();
      run = 1'b0;
      testsRun++;
      if (tstate !== oneHot(0) || running !== 1'b1 || halted !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL halt_resume: tstate=%h running=%b halted=%b, expected %h 1 0", tstate, running, halted, oneHot(0));
      end
   endtask

   task automatic test_step();
      applyReset();
      stepMode = 1'b1;
      run = 1'b1;
      tick();
      run = 1'b0;
      for (int p = 1; p <= 3; p++) begin
         for (int w = 0; w < 3; w++) tick();
         testsRun++;
         if (tstate !== oneHot(p - 1)) begin
            testsFailed++;
            $display("[TB] FAIL step_hold%0d: tstate=%h, expected %h", p, tstate, oneHot(p - 1));
         end
         step = 1'b1;
         tick();
         step = 1'b0;
         testsRun++;
         if (tstate !== oneHot(p)) begin
            testsFailed++;
            $display("[TB] FAIL step_pulse%0d: tstate=%h, expected %h", p, tstate, oneHot(p));
         end
      end
      stepMode = 1'b0;
   endtask

   task automatic test_overrun();
      applyReset();
      run = 1'b1;
      tick();
      run = 1'b0;
      for (int k = 0; k < NUM_T - 1; k++) tick();
      testsRun++;
      if (tstate !== oneHot(NUM_T - 1) || fault !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL overrun_last: tstate=%h fault=%b, expected %h fault=0", tstate, fault, oneHot(NUM_T - 1));
      end
      tick();
      testsRun++;
      if (tstate !== oneHot(0) || fault !== 1'b1 || instrCount !== 16'd0 || instrDone !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL overrun_wrap: tstate=%h fault=%b cnt=%0d done=%b, expected %h 1 0 0",
                  tstate, fault, instrCount, instrDone, oneHot(0));
      end
      restartN = 1'b0;
      tick();
      restartN = 1'b1;
      tick();
      testsRun++;
      if (fault !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL overrun_sticky: fault=%b, expected 1", fault);
      end
   endtask

   task automatic test_count_wrap();
      applyReset();
      run = 1'b1;
      tick();
      run = 1'b0;
      restartN = 1'b0;
      for (int k = 0; k < 65535; k++) tick();
      testsRun++;
      if (instrCount !== 16'hFFFF) begin
         testsFailed++;
         $display("[TB] FAIL count_preload: cnt=%h, expected ffff", instrCount);
      end
      tick();
      restartN = 1'b1;
      testsRun++;
      if (instrCount !== 16'h0000 || instrDone !== 1'b1 || fault !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL count_wrap: cnt=%h done=%b fault=%b, expected 0000 1 0", instrCount, instrDone, fault);
      end
   endtask

   task automatic test_reset_mid();
      applyReset();
      run = 1'b1;
      tick();
      run = 1'b0;
      for (int k = 0; k < 7; k++) tick();
      testsRun++;
      if (tstate !== oneHot(7)) begin
         testsFailed++;
         $display("[TB] FAIL mid_at_t7: tstate=%h, expected %h", tstate, oneHot(7));
      end
      restartN = 1'b0;
      rstN = 1'b0;
      tick();
      rstN = 1'b1;
      restartN = 1'b1;
      testsRun++;
      if ({tstate, running, halted, instrDone, instrCount, fault} !== '0) begin
         testsFailed++;
         $display("[TB] FAIL mid_reset: tstate=%h run=%b halt=%b done=%b cnt=%0d fault=%b, expected all zero",
                  tstate, running, halted, instrDone, instrCount, fault);
      end
   endtask

   task automatic test_random();
      logic [NUM_T-1:0] expT;
      applyReset();
      for (int c = 0; c < 3000; c++) begin
         rstN     = ($urandom_range(0, 63) != 0);
         run      = ($urandom_range(0, 3) == 0);
         restartN = ($urandom_range(0, 9) != 0);
         halt     = ($urandom_range(0, 2) == 0);
         step     = $urandom_range(0, 1) != 0;
         if ($urandom_range(0, 31) == 0) stepMode = ~stepMode;
         tick();
         expT = oneHot(mT);
         testsRun++;
         if (tstate !== expT || running !== (mMode == 1) || halted !== (mMode == 2) ||
             instrDone !== mDone || instrCount !== CNT_W'(mCount) || fault !== mFault) begin
            testsFailed++;
            $display("[TB] FAIL random c%0d: got t=%h r=%b h=%b d=%b n=%0d f=%b, expected t=%h r=%b h=%b d=%b n=%0d f=%b",
                     c, tstate, running, halted, instrDone, instrCount, fault,
                     expT, mMode == 1, mMode == 2, mDone, mCount, mFault);
         end
      end
      rstN = 1'b1; run = 1'b0; restartN = 1'b1; halt = 1'b0; step = 1'b0; stepMode = 1'b0;
   endtask

   // Scenario sequence and summary
   initial begin
      test_reset();
      test_nop_restart();
      test_halt();
      test_step();
      test_overrun();
      test_count_wrap();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/m_tstate_sequencer.md
M_TSTATE_SEQUENCER -- requirements
Module: mTstateSequencer

Interface
REQ-001 Parameter NUM_T, default 18, SHALL set the number of one-hot T-states, T0..T(NUM_T-1).
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the retired-instruction counter.
REQ-003 iClk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 iRST_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 iRun  input  1  SHALL be the start/resume request, sampled each cycle.
REQ-006 iRestart_n  input  1  SHALL be the active-low end-of-instruction strobe, driven from the control matrix oRST.
REQ-007 iHalt  input  1  SHALL be the halt strobe, driven from the control matrix oCLK_RST.
REQ-008 iStepMode  input  1  SHALL select single-step operation when 1.
REQ-009 iStep  input  1  SHALL be the one-cycle step pulse; it is honoured only when iStepMode=1.
REQ-010 oTstate  output  NUM_T  SHALL be the one-hot T-state vector that feeds the control matrix iTstate.
REQ-011 oRunning  output  1  SHALL be 1 in state RUN.
REQ-012 oHalted  output  1  SHALL be 1 in state HALTED.
REQ-013 oInstrDone  output  1  SHALL pulse for one cycle when an instruction retires.
REQ-014 oInstrCount  output  CNT_W  SHALL be the retired-instruction count.
REQ-015 oFault  output  1  SHALL be a sticky flag set on ring overrun.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and HALTED.
REQ-017 In IDLE and HALTED, oTstate SHALL be all-zero.
REQ-018 IDLE with iRun=1 SHALL go to RUN with oTstate=T0 on the next cycle; iRun=0 SHALL hold IDLE.
REQ-019 In RUN, the advance enable SHALL be: iStepMode=0, or iStep=1.
REQ-020 In RUN, events SHALL be evaluated in this priority order: halt > restart > advance > hold.
REQ-021 Halt: iHalt=1 while oTstate=T3 SHALL go to HALTED with oTstate=0 next cycle; this SHALL NOT count as a retirement; it is not gated by step mode.
REQ-022 Restart: iRestart_n=0 SHALL load T0 next cycle, pulse oInstrDone and increment oInstrCount; it is not gated by step mode.
REQ-023 Advance: with the enable set, oTstate SHALL shift one position (Tk -> Tk+1).
REQ-024 Hold: with the enable clear, oTstate SHALL be unchanged.
REQ-025 Overrun: advance from T(NUM_T-1) without restart SHALL wrap to T0, set oFault, and SHALL NOT increment oInstrCount.
REQ-026 iHalt asserted outside T3 SHALL be ignored.
REQ-027 HALTED with iRun=1 SHALL go to RUN at T0 next cycle; otherwise it SHALL hold.
REQ-028 iRun in RUN SHALL be ignored.
REQ-029 iStep in IDLE or HALTED SHALL be ignored.
REQ-030 oInstrCount SHALL wrap from all-ones to 0 without setting a flag.
REQ-031 oTstate SHALL be one-hot in RUN and zero elsewhere; no other pattern is reachable.
REQ-032 All outputs SHALL be registered, with zero combinational path from any input to any output.

Reset
REQ-033 iRST_n=0 at a clock edge SHALL force, on that edge: state IDLE, oTstate=0, oRunning=0, oHalted=0, oInstrDone=0, oInstrCount=0, oFault=0.
REQ-034 Reset SHALL take priority over every other event, including mid-instruction and in HALTED.
REQ-035 Reset SHALL abandon any in-flight instruction without a retirement pulse.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding (IDLE, RUN, HALTED), the default NUM_T, the default CNT_W, and the T3 halt index.
REQ-037 The one-hot shift/load/clear ring SHALL be one sub-module, mRingCounter, with controls load-T0, shift and clear.
REQ-038 The FSM, counter and fault logic SHALL reside in mTstateSequencer.

Verification
REQ-039 Reset then iRun pulse; hold iRestart_n=0 at T3 (NOP) -> sequence T0,T1,T2,T3,T0; oInstrDone pulses once; oInstrCount=1.
REQ-040 RUN, iHalt=1 at T3 -> HALTED, oTstate=0, oHalted=1, count unchanged. Then iRun -> T0 next cycle.
REQ-041 iStepMode=1, three iStep pulses spaced 4 cycles apart from T0 -> T3 reached only after the third pulse; oTstate holds between pulses.
REQ-042 Run 18 cycles with iRestart_n=1 throughout -> wrap T17->T0; oFault=1 and remains 1; count=0.
REQ-043 Preload oInstrCount=16'hFFFF via repeated restarts, one more restart -> oInstrCount=0, oInstrDone pulses.
REQ-044 iRST_n=0 at T7 while iRestart_n=0 -> next cycle IDLE, oTstate=0, oInstrDone=0, all counters 0.
